// File: rtl/rtl_kernel_wizard_1_example_stream_arb_pkg.sv
// Shared types for the stream arbiter slice.
// FSM state encoding and grant-index width helper.
package rtl_kernel_wizard_1_example_stream_arb_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    XFER = 1'b1
  } state_t;

  function automatic int idx_w(input int n);
    return (n > 2) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rtl_kernel_wizard_1_example_rr_pick.sv
// Round-robin pick: first valid requester at or after ptr_i.
// Purely combinational.
module rtl_kernel_wizard_1_example_rr_pick
  import rtl_kernel_wizard_1_example_stream_arb_pkg::*;
#(
  parameter int N = 4,
  parameter int W = idx_w(N)
) (
  input  logic [N-1:0] valid_i,
  input  logic [W-1:0] ptr_i,
  output logic [N-1:0] onehot_o,
  output logic [W-1:0] idx_o,
  output logic         any_o
);

  always_comb begin
    onehot_o = '0;
    idx_o    = '0;
    any_o    = 1'b0;
    for (int k = 0; k < N; k++) begin
      if (!any_o && valid_i[(int'(ptr_i) + k) % N]) begin
        any_o = 1'b1;
        idx_o = W'((int'(ptr_i) + k) % N);
      end
    end
    if (any_o) onehot_o[idx_o] = 1'b1;
  end

endmodule

// File: rtl/rtl_kernel_wizard_1_example_stream_arb.sv
// Packet-granular round-robin arbiter feeding one AXI4-Stream
// from C_NUM_REQ requesters, with per-requester packet counters.
module rtl_kernel_wizard_1_example_stream_arb
  import rtl_kernel_wizard_1_example_stream_arb_pkg::*;
#(
  parameter  int C_NUM_REQ          = 4,
  parameter  int C_AXIS_TDATA_WIDTH = 512,
  parameter  int C_CNT_WIDTH        = 32,
  localparam int IW = idx_w(C_NUM_REQ),
  localparam int DW = C_AXIS_TDATA_WIDTH,
  localparam int KW = C_AXIS_TDATA_WIDTH / 8
) (
  input  logic                           aclk,
  input  logic                           aresetn,
  input  logic                           enable,
  input  logic [C_NUM_REQ-1:0]           s_axis_tvalid,
  output logic [C_NUM_REQ-1:0]           s_axis_tready,
  input  logic [C_NUM_REQ-1:0]           s_axis_tlast,
  input  logic [C_NUM_REQ*DW-1:0]        s_axis_tdata,
  input  logic [C_NUM_REQ*KW-1:0]        s_axis_tkeep,
  output logic                           m_axis_tvalid,
  input  logic                           m_axis_tready,
  output logic [DW-1:0]                  m_axis_tdata,
  output logic [KW-1:0]                  m_axis_tkeep,
  output logic                           m_axis_tlast,
  output logic [IW-1:0]                  m_axis_tid,
  output logic                           busy,
  output logic [C_NUM_REQ*C_CNT_WIDTH-1:0] pkt_count
);

  localparam logic [IW-1:0] LAST = IW'(C_NUM_REQ - 1);

  state_t                              state_q;
  logic [IW-1:0]                       grant_q;
  logic [C_NUM_REQ-1:0]                grant_oh_q;
  logic [IW-1:0]                       rr_ptr_q;
  logic [IW-1:0]                       rr_ptr_d;
  logic [C_NUM_REQ-1:0][C_CNT_WIDTH-1:0] cnt_q;

  logic [C_NUM_REQ-1:0] pick_oh;
  logic [IW-1:0]        pick_idx;
  logic                 pick_any;
  logic                 xfer;
  logic                 sel_valid;
  logic                 sel_last;
  logic                 end_pkt;

  rtl_kernel_wizard_1_example_rr_pick #(
    .N (C_NUM_REQ),
    .W (IW)
  ) u_pick (
    .valid_i  (s_axis_tvalid),
    .ptr_i    (rr_ptr_q),
    .onehot_o (pick_oh),
    .idx_o    (pick_idx),
    .any_o    (pick_any)
  );

  assign xfer      = (state_q == XFER);
  assign sel_valid = s_axis_tvalid[grant_q];
  assign sel_last  = s_axis_tlast[grant_q];
  assign end_pkt   = xfer & sel_valid & m_axis_tready & sel_last;
  assign rr_ptr_d  = (grant_q == LAST) ? '0 : grant_q + 1'b1;

  assign m_axis_tvalid = xfer & sel_valid;
  assign m_axis_tdata  = s_axis_tdata[int'(grant_q)*DW +: DW];
  assign m_axis_tkeep  = s_axis_tkeep[int'(grant_q)*KW +: KW];
  assign m_axis_tlast  = sel_last;
  assign m_axis_tid    = xfer ? grant_q : '0;
  assign busy          = xfer;
  assign pkt_count     = cnt_q;

  assign s_axis_tready =
    grant_oh_q & {C_NUM_REQ{xfer & m_axis_tready}};

  // Grant is only re-evaluated from IDLE, so a packet is never split.
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      state_q    <= IDLE;
      grant_q    <= '0;
      grant_oh_q <= '0;
      rr_ptr_q   <= '0;
      cnt_q      <= '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (enable && pick_any) begin
            grant_q    <= pick_idx;
            grant_oh_q <= pick_oh;
            state_q    <= XFER;
          end
        end
        XFER: begin
          if (end_pkt) begin
            state_q        <= IDLE;
            rr_ptr_q       <= rr_ptr_d;
            cnt_q[grant_q] <= cnt_q[grant_q] + C_CNT_WIDTH'(1);
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/rtl_kernel_wizard_1_example_stream_arb.md
RTL_KERNEL_WIZARD_1_EXAMPLE_STREAM_ARB -- requirements
Module: rtl_kernel_wizard_1_example_stream_arb

Interface
REQ-001 SHALL have parameter C_NUM_REQ, default 4, number of AXI4-Stream requesters sharing the adder datapath (2..8).
REQ-002 SHALL have parameter C_AXIS_TDATA_WIDTH, default 512, tdata width of every stream.
REQ-003 SHALL have parameter C_CNT_WIDTH, default 32, width of each per-requester packet counter.
REQ-004 SHALL have port aclk  input  1  single clock; all logic on its rising edge.
REQ-005 SHALL have port aresetn  input  1  reset, synchronous, active-low.
REQ-006 SHALL have port enable  input  1  arbitration allowed when high.
REQ-007 SHALL have ports s_axis_tvalid/tready/tlast  input/output/input  C_NUM_REQ each  per-requester handshake and end-of-packet.
REQ-008 SHALL have ports s_axis_tdata/tkeep  input  C_NUM_REQ*C_AXIS_TDATA_WIDTH / C_NUM_REQ*C_AXIS_TDATA_WIDTH/8  packed per-requester payload, requester i at slice i.
REQ-009 SHALL have ports m_axis_tvalid/tready/tdata/tkeep/tlast  output/input/output/output/output  1/1/C_AXIS_TDATA_WIDTH/C_AXIS_TDATA_WIDTH/8/1  stream to adder.
REQ-010 SHALL have port m_axis_tid  output  clog2(C_NUM_REQ) (min 1)  index of granted requester.
REQ-011 SHALL have port busy  output  1  high while in XFER.
REQ-012 SHALL have port pkt_count  output  C_NUM_REQ*C_CNT_WIDTH  completed packets per requester.

Function
REQ-013 SHALL implement FSM with states IDLE and XFER.
REQ-014 IDLE: if enable=1 and any s_axis_tvalid=1, SHALL register grant = first valid requester at or after rr_ptr (modulo C_NUM_REQ) and enter XFER next cycle; no beat transferred in IDLE.
REQ-015 XFER: m_axis_tvalid/tdata/tkeep/tlast SHALL be combinationally muxed from granted requester; s_axis_tready[grant]=m_axis_tready; all other s_axis_tready=0.
REQ-016 In IDLE every s_axis_tready and m_axis_tvalid SHALL be 0.
REQ-017 Grant SHALL be held for the whole packet; switch only after beat with tvalid&tready&tlast accepted.
REQ-018 On accepted tlast beat: state->IDLE, rr_ptr=grant+1 (wrap to 0 after C_NUM_REQ-1), pkt_count[grant] += 1, all in same edge.
REQ-019 Minimum gap between packets SHALL be exactly one IDLE cycle; single-beat packet occupies one XFER cycle when m_axis_tready=1.
REQ-020 pkt_count SHALL wrap modulo 2^C_CNT_WIDTH, no saturation.
REQ-021 enable deasserted in XFER SHALL NOT abort packet; block completes it, then stays IDLE until enable=1.
REQ-022 Requester deasserting tvalid mid-packet SHALL keep grant (bubbles pass through, m_axis_tvalid=0).
REQ-023 m_axis_tid SHALL equal grant in XFER, 0 in IDLE.
REQ-024 Arbitration SHALL be starvation-free: any requester holding tvalid waits at most C_NUM_REQ-1 packets.

Reset
REQ-025 aresetn=0 at a clock edge SHALL force IDLE, grant=0, rr_ptr=0, pkt_count=0, busy=0, all tready/m_axis_tvalid=0, including mid-packet (partial packet abandoned, no count).
REQ-026 First arbitration after reset SHALL search from requester 0.

Structure
REQ-027 Shared package SHALL hold state enum (IDLE, XFER) and grant-index width function.
REQ-028 Round-robin priority search SHALL be a sub-module rtl_kernel_wizard_1_example_rr_pick (valid vector + pointer in, one-hot/index + any-valid out, purely combinational).
REQ-029 Block SHALL instantiate no clock-domain-crossing or FIFO primitives.

Verification
REQ-030 All 4 requesters valid with 3-beat packets, m_axis_tready=1 -> grant order 0,1,2,3,0; tid matches; 1 idle cycle between packets; pkt_count each 1 after first round.
REQ-031 Only requester 2 valid, 5 packets -> back-to-back grants to 2; pkt_count[2]=5, others 0.
REQ-032 Requester 1 in 4-beat packet, m_axis_tready toggles 1010..., requester 3 valid throughout -> no grant change before tlast; data order intact; then grant 3.
REQ-033 enable dropped on beat 2 of 4 -> beats 3,4 delivered, then IDLE held with requesters valid until enable=1.
REQ-034 aresetn low on beat 2 of 4 of requester 0 -> next cycle all tready=0, pkt_count=0; after release first grant to lowest valid index from 0.
REQ-035 C_CNT_WIDTH=4, 17 packets from requester 0 -> pkt_count[0]=1 (wrap).
